mem_req_initiator: RTL and testbench
====================================

Name: mem_req_initiator

Overview:
- Synthesizable initiator for the single-outstanding RAM request/ack protocol used by the core's external memory port (readReq/writeReq pulse, readAck/writeAck reply).
- Sits between the core load/store logic and the external RAM responder.
- Accepts byte/half/word loads and stores and returns sign- or zero-extended load data.
- Sub-word stores use read-modify-write, because the responder always transfers 4 bytes, little-endian, at ramAddress..ramAddress+3.

Parameters:
- ADDR_W, 32, width of byte address.
- TIMEOUT_CYCLES, 255, cycles waited for an ack before abort. Used only with MEMREQ_TIMEOUT_EN.

Ports:
- clk  in  1  clock, all logic on posedge
- reset  in  1  synchronous, active-high
- cmdValid  in  1  core command present
- cmdReady  out  1  block can accept a command (IDLE)
- cmdWrite  in  1  1=store, 0=load
- cmdSize  in  2  0=byte, 1=half, 2=word, 3=reserved (treated as word)
- cmdSigned  in  1  sign-extend load result
- cmdAddr  in  ADDR_W  byte address
- cmdData  in  32  store data (low bytes used for sub-word)
- rspValid  out  1  one-cycle pulse: command complete
- rspData  out  32  load result (0 for stores)
- rspErr  out  1  valid with rspValid; timeout abort
- ramAddress  out  ADDR_W  request address
- ramOut  out  32  write data
- readReq  out  1  read request pulse
- writeReq  out  1  write request pulse
- ramValue  in  32  read data, valid when readAck=1
- readAck  in  1  read done
- writeAck  in  1  write done

Behaviour:
- Reset values: cmdReady=0 during reset, 1 the cycle after. rspValid=0, rspData=0, rspErr=0, readReq=0, writeReq=0, ramAddress=0, ramOut=0. State=IDLE.
- Handshake: a command is accepted on a posedge with cmdValid&cmdReady. All cmd fields are latched at acceptance.
- States: IDLE, RD_REQ, RD_WAIT, MERGE, WR_REQ, WR_WAIT, DONE.
- Transitions from IDLE on accept:
  - load -> RD_REQ
  - word store -> WR_REQ
  - sub-word store -> RD_REQ (RMW)
- RD_REQ: readReq=1 for exactly one cycle, then RD_WAIT. writeReq behaves the same in WR_REQ. Requests are never held high, so the responder sees exactly one request per access.
- ramAddress:
  - loads and word stores: latched cmdAddr
  - sub-word RMW: cmdAddr
  - never aligned down
- ramAddress and ramOut are held stable from the REQ cycle until the matching ack is sampled.
- RD_WAIT: on readAck=1, capture ramValue.
  - load -> DONE
  - RMW -> MERGE
- MERGE, one cycle:
  - ramOut = read word with byte 0 (size 0) or bytes 1:0 (size 1) replaced by cmdData low bytes
  - then WR_REQ
- WR_WAIT: on writeAck=1 -> DONE.
- DONE: rspValid=1 for one cycle, rspErr per abort, then IDLE. cmdReady is asserted only in IDLE. Minimum command-to-command spacing is therefore 1 cycle after rspValid.
- Load result:
  - byte: ramValue[7:0], extended to 32 bits by sign (cmdSigned=1) or zero
  - half: ramValue[15:0], extended the same way
  - word: unchanged
- rspData holds its value until the next rspValid.
- Ack rules:
  - Only the expected ack is honoured (readAck in RD_WAIT, writeAck in WR_WAIT).
  - Acks in any other state, including simultaneous readAck&writeAck outside the expected one, are ignored.
  - An ack in the same cycle as the REQ pulse is ignored.
- Reset mid-operation: immediately IDLE, req lines low. A late ack arriving after reset is ignored.
- Address wrap: cmdAddr near 2^ADDR_W-1 is passed through unchanged. Wrap is the responder's concern.

Optional Feature:
- MEMREQ_TIMEOUT_EN defined:
  - An 8+ bit counter starts at 0 when entering RD_WAIT or WR_WAIT and increments each cycle without the ack.
  - When it reaches TIMEOUT_CYCLES: go to DONE with rspErr=1, rspData=0. An RMW aborts without writing.
  - The counter clears on ack or reset.
- Not defined: wait indefinitely, counter absent, rspErr tied 0.

Test Plan:
- Word load at 0x10, RAM bytes 10..13 = 78 56 34 12, responder ack 1 cycle after req -> readReq exactly 1 cycle high, rspData=0x12345678, rspErr=0, rspValid 1 cycle.
- Signed byte load at 0x20 with byte 0x80 -> rspData=0xFFFFFF80. Same command with cmdSigned=0 -> 0x00000080. Half load of 0x8001 signed -> 0xFFFF8001.
- Byte store 0xAB to 0x30 holding 0x11223344 -> read then write, written word 0x112233AB, ramOut stable until writeAck, rspValid after writeAck.
- Word store 0xDEADBEEF to 0x40 -> no readReq, single writeReq pulse. A subsequent word load of 0x40 returns 0xDEADBEEF.
- Reset asserted during RD_WAIT, then a stray readAck -> block in IDLE, no rspValid, cmdReady=1 one cycle after reset release.
- With MEMREQ_TIMEOUT_EN and TIMEOUT_CYCLES=4, responder never acks -> rspValid with rspErr=1 exactly 4 cycles after entering RD_WAIT, rspData=0, no writeReq.

Source files
------------

// File: rtl/mem_req_initiator.sv
// Single-outstanding RAM request/ack initiator: byte/half/word loads and stores, sub-word stores by read-modify-write.
// Optional ack timeout abort is built when MEMREQ_TIMEOUT_EN is defined.
module mem_req_initiator #(
   parameter int ADDR_W         = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cmdValid,
   output logic              cmdReady,
   input  logic              cmdWrite,
   input  logic [1:0]        cmdSize,
   input  logic              cmdSigned,
   input  logic [ADDR_W-1:0] cmdAddr,
   input  logic [31:0]       cmdData,
   output logic              rspValid,
   output logic [31:0]       rspData,
   output logic              rspErr,
   output logic [ADDR_W-1:0] ramAddress,
   output logic [31:0]       ramOut,
   output logic              readReq,
   output logic              writeReq,
   input  logic [31:0]       ramValue,
   input  logic              readAck,
   input  logic              writeAck,
   output logic [2:0]        fsm_state
);

   // cmd side: accepted on posedge with cmdValid & cmdReady, cmdReady only in IDLE.
   // ram side: one-cycle req pulse, address/data held until the matching ack; acks outside the wait state are dropped.
   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] RD_REQ  = 3'd1;
   localparam logic [2:0] RD_WAIT = 3'd2;
   localparam logic [2:0] MERGE   = 3'd3;
   localparam logic [2:0] WR_REQ  = 3'd4;
   localparam logic [2:0] WR_WAIT = 3'd5;
   localparam logic [2:0] DONE    = 3'd6;

   logic [2:0]  state;
   logic        c_write;
   logic        c_signed;
   logic [1:0]  c_size;
   logic [15:0] c_data;
   logic [31:0] rd_word;
   logic        err_q;
   logic        tmo_hit;

   function automatic logic [31:0] extend(input logic [31:0] v, input logic [1:0] sz, input logic sgn);
      case (sz)
         2'd0:    extend = {{24{sgn & v[7]}}, v[7:0]};
         2'd1:    extend = {{16{sgn & v[15]}}, v[15:0]};
         default: extend = v;
      endcase
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] w, input logic [15:0] d, input logic [1:0] sz);
      case (sz)
         2'd0:    merge = {w[31:8], d[7:0]};
         default: merge = {w[31:16], d[15:0]};
      endcase
   endfunction

`ifdef MEMREQ_TIMEOUT_EN
   localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
   logic [CNT_W-1:0] tmo_cnt;

   // Counts only while waiting without the expected ack, so it is zero on every wait entry.
   always_ff @(posedge clk) begin
      if (reset)
         tmo_cnt <= '0;
      else if ((state == RD_WAIT && !readAck) || (state == WR_WAIT && !writeAck))
         tmo_cnt <= tmo_cnt + CNT_W'(1);
      else
         tmo_cnt <= '0;
   end

   assign tmo_hit = (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
   localparam int unused_timeout = TIMEOUT_CYCLES;
   assign tmo_hit = 1'b0;
`endif

   assign cmdReady  = (state == IDLE) && !reset;
   assign readReq   = (state == RD_REQ);
   assign writeReq  = (state == WR_REQ);
   assign rspValid  = (state == DONE);
   assign rspErr    = rspValid && err_q;
   assign fsm_state = state;

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         c_write    <= 1'b0;
         c_signed   <= 1'b0;
         c_size     <= 2'd0;
         c_data     <= '0;
         rd_word    <= '0;
         err_q      <= 1'b0;
         rspData    <= '0;
         ramAddress <= '0;
         ramOut     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (cmdValid) begin
                  c_write    <= cmdWrite;
                  c_signed   <= cmdSigned;
                  c_size     <= cmdSize;
                  c_data     <= cmdData[15:0];
                  ramAddress <= cmdAddr;
                  // Word (and reserved-size) stores skip the read; sub-word stores go through RMW.
                  if (cmdWrite && cmdSize[1]) begin
                     ramOut <= cmdData;
                     state  <= WR_REQ;
                  end else begin
                     state  <= RD_REQ;
                  end
               end
            end
            RD_REQ: state <= RD_WAIT;
            RD_WAIT: begin
               if (readAck) begin
                  rd_word <= ramValue;
                  if (c_write) begin
                     state <= MERGE;
                  end else begin
                     rspData <= extend(ramValue, c_size, c_signed);
                     err_q   <= 1'b0;
                     state   <= DONE;
                  end
               end else if (tmo_hit) begin
                  rspData <= '0;
                  err_q   <= 1'b1;
                  state   <= DONE;
               end
            end
            MERGE: begin
               ramOut <= merge(rd_word, c_data, c_size);
               state  <= WR_REQ;
            end
            WR_REQ: state <= WR_WAIT;
            WR_WAIT: begin
               if (writeAck) begin
                  rspData <= '0;
                  err_q   <= 1'b0;
                  state   <= DONE;
               end else if (tmo_hit) begin
                  rspData <= '0;
                  err_q   <= 1'b1;
                  state   <= DONE;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_req_initiator.sv
// Self-checking bench for mem_req_initiator: vector table, byte-addressed RAM responder, reset and timeout sequences.
module tb_mem_req_initiator;

   logic        clk;
   logic        reset;
   logic        cmdValid;
   logic        cmdReady;
   logic        cmdWrite;
   logic [1:0]  cmdSize;
   logic        cmdSigned;
   logic [31:0] cmdAddr;
   logic [31:0] cmdData;
   logic        rspValid;
   logic [31:0] rspData;
   logic        rspErr;
   logic [31:0] ramAddress;
   logic [31:0] ramOut;
   logic        readReq;
   logic        writeReq;
   logic [31:0] ramValue;
   logic        readAck;
   logic        writeAck;
   logic [2:0]  fsm_state;

   int          checks = 0;
   int          errors = 0;
   logic [32:0] exp_q[$];

   logic [7:0]  mem [logic [31:0]];
   int          rd_pulses   = 0;
   int          wr_pulses   = 0;
   int          rsp_pulses  = 0;
   int          wr_unstable = 0;
   logic [31:0] last_req_addr = '0;
   logic [31:0] last_wr_data  = '0;
   bit          ack_en        = 1'b1;
   int          stray_cnt     = 0;

   typedef struct {
      logic        wr;
      logic [1:0]  sz;
      logic        sgn;
      logic [31:0] addr;
      logic [31:0] data;
      logic [31:0] exp_rsp;
      logic [31:0] exp_wdata;
   } vec_t;

   vec_t vecs[15];

   mem_req_initiator #(.ADDR_W(32), .TIMEOUT_CYCLES(4)) dut (
      .clk(clk), .reset(reset), .cmdValid(cmdValid), .cmdReady(cmdReady),
      .cmdWrite(cmdWrite), .cmdSize(cmdSize), .cmdSigned(cmdSigned), .cmdAddr(cmdAddr),
      .cmdData(cmdData), .rspValid(rspValid), .rspData(rspData), .rspErr(rspErr),
      .ramAddress(ramAddress), .ramOut(ramOut), .readReq(readReq), .writeReq(writeReq),
      .ramValue(ramValue), .readAck(readAck), .writeAck(writeAck), .fsm_state(fsm_state)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] rd_mem(input logic [31:0] a);
      logic [31:0] r;
      logic [31:0] k;
      r = '0;
      for (int i = 0; i < 4; i++) begin
         k = a + 32'(i);
         r[8*i +: 8] = mem.exists(k) ? mem[k] : 8'h00;
      end
      return r;
   endfunction

   task automatic put_word(input logic [31:0] a, input logic [31:0] w);
      for (int i = 0; i < 4; i++) mem[a + 32'(i)] = w[8*i +: 8];
   endtask

   function automatic logic [31:0] model_load(input logic [31:0] w, input logic [1:0] sz, input logic sgn);
      logic [31:0] m;
      logic [31:0] s;
      case (sz)
         2'd0:    begin m = w & 32'h0000_00FF; s = 32'h0000_0080; end
         2'd1:    begin m = w & 32'h0000_FFFF; s = 32'h0000_8000; end
         default: begin m = w;                 s = 32'h0;         end
      endcase
      return sgn ? ((m ^ s) - s) : m;
   endfunction

   function automatic logic [31:0] model_merge(input logic [31:0] w, input logic [31:0] d, input logic [1:0] sz);
      logic [31:0] mask;
      mask = (sz == 2'd0) ? 32'h0000_00FF : (sz == 2'd1) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
      return (w & ~mask) | (d & mask);
   endfunction

   task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Pulse counters sampled on the falling edge.
   initial begin
      forever begin
         @(negedge clk);
         if (readReq === 1'b1) rd_pulses++;
         if (writeReq === 1'b1) wr_pulses++;
         if (rspValid === 1'b1) rsp_pulses++;
      end
   end

   // RAM responder: little-endian 4-byte transfers at ramAddress, ack 1..3 cycles after the request.
   initial begin
      logic [31:0] a;
      logic [31:0] d;
      int          lat;
      int          stray_done;
      stray_done = 0;
      put_word(32'h10, 32'h1234_5678);
      put_word(32'h20, 32'h0000_0080);
      put_word(32'h24, 32'h0000_8001);
      put_word(32'h30, 32'h1122_3344);
      put_word(32'h34, 32'h0000_0000);
      put_word(32'h40, 32'h0000_0000);
      put_word(32'hFFFF_FFFE, 32'h4433_2211);
      for (int i = 0; i < 36; i += 4) put_word(32'h100 + 32'(i), $urandom);
      readAck  = 1'b0;
      writeAck = 1'b0;
      ramValue = '0;
      forever begin
         @(negedge clk);
         if (stray_cnt != stray_done) begin
            stray_done = stray_cnt;
            readAck    = 1'b1;
            writeAck   = 1'b1;
            ramValue   = 32'hBADB_AD00;
            @(negedge clk);
            readAck    = 1'b0;
            writeAck   = 1'b0;
         end else if (readReq === 1'b1) begin
            a = ramAddress;
            last_req_addr = a;
            lat = $urandom_range(1, 3);
            repeat (lat) @(negedge clk);
            if (ack_en) begin
               readAck  = 1'b1;
               ramValue = rd_mem(a);
               @(negedge clk);
               readAck  = 1'b0;
               ramValue = $urandom;
            end
         end else if (writeReq === 1'b1) begin
            a = ramAddress;
            d = ramOut;
            last_req_addr = a;
            last_wr_data  = d;
            lat = $urandom_range(1, 3);
            repeat (lat) begin
               @(negedge clk);
               if (ramAddress !== a || ramOut !== d) wr_unstable++;
            end
            if (ack_en) begin
               writeAck = 1'b1;
               put_word(a, d);
               @(negedge clk);
               writeAck = 1'b0;
            end
         end
      end
   end

   task automatic do_cmd(input logic wr, input logic [1:0] sz, input logic sgn, input logic [31:0] addr,
                         input logic [31:0] data, input logic [32:0] exp_rsp, input logic [31:0] exp_wdata);
      int          n;
      int          rd0;
      int          wr0;
      int          rsp0;
      int          unst0;
      int          n_rd;
      int          n_wr;
      logic [32:0] e;
      n = 0;
      while (cmdReady !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (cmdReady !== 1'b1) chk("cmd_ready_timeout", 33'(cmdReady), 33'(1));
      rd0   = rd_pulses;
      wr0   = wr_pulses;
      rsp0  = rsp_pulses;
      unst0 = wr_unstable;
      n_rd  = (!wr || !sz[1]) ? 1 : 0;
      n_wr  = (wr && !(exp_rsp[32] && n_rd == 1)) ? 1 : 0;
      cmdValid  = 1'b1;
      cmdWrite  = wr;
      cmdSize   = sz;
      cmdSigned = sgn;
      cmdAddr   = addr;
      cmdData   = data;
      exp_q.push_back(exp_rsp);
      @(negedge clk);
      cmdValid  = 1'b0;
      cmdAddr   = $urandom;
      cmdData   = $urandom;
      cmdSigned = ~sgn;
      n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         if (rspValid === 1'b1) begin
            e = exp_q.pop_front();
            chk("rsp", {rspErr, rspData}, e);
         end else begin
            @(negedge clk);
            n++;
         end
      end
      if (exp_q.size() != 0) begin
         chk("rsp_timeout", 33'(rsp_pulses - rsp0), 33'(1));
         exp_q.delete();
      end
      @(negedge clk);
      chk("rd_pulses", 33'(rd_pulses - rd0), 33'(n_rd));
      chk("wr_pulses", 33'(wr_pulses - wr0), 33'(n_wr));
      chk("rsp_pulses", 33'(rsp_pulses - rsp0), 33'(1));
      chk("ram_addr", {1'b0, last_req_addr}, {1'b0, addr});
      if (n_wr == 1) begin
         chk("wr_data", {1'b0, last_wr_data}, {1'b0, exp_wdata});
         chk("wr_stable", 33'(wr_unstable - unst0), 33'(0));
      end
   endtask

   initial begin
      int n;
      int rd0;
      int wr0;
      int rsp0;
      reset     = 1'b1;
      cmdValid  = 1'b0;
      cmdWrite  = 1'b0;
      cmdSize   = 2'd0;
      cmdSigned = 1'b0;
      cmdAddr   = '0;
      cmdData   = '0;

      //            wr    sz    sgn   addr          data          exp_rsp       exp_wdata
      vecs[0]  = '{1'b0, 2'd2, 1'b0, 32'h10,       32'h0,        32'h1234_5678, 32'h0};
      vecs[1]  = '{1'b0, 2'd0, 1'b1, 32'h20,       32'h0,        32'hFFFF_FF80, 32'h0};
      vecs[2]  = '{1'b0, 2'd0, 1'b0, 32'h20,       32'h0,        32'h0000_0080, 32'h0};
      vecs[3]  = '{1'b0, 2'd1, 1'b1, 32'h24,       32'h0,        32'hFFFF_8001, 32'h0};
      vecs[4]  = '{1'b0, 2'd1, 1'b0, 32'h24,       32'h0,        32'h0000_8001, 32'h0};
      vecs[5]  = '{1'b1, 2'd0, 1'b0, 32'h30,       32'hFFFF_FFAB, 32'h0,        32'h1122_33AB};
      vecs[6]  = '{1'b0, 2'd2, 1'b0, 32'h30,       32'h0,        32'h1122_33AB, 32'h0};
      vecs[7]  = '{1'b1, 2'd1, 1'b0, 32'h32,       32'h1234_CAFE, 32'h0,        32'h0000_CAFE};
      vecs[8]  = '{1'b0, 2'd2, 1'b0, 32'h30,       32'h0,        32'hCAFE_33AB, 32'h0};
      vecs[9]  = '{1'b1, 2'd2, 1'b0, 32'h40,       32'hDEAD_BEEF, 32'h0,        32'hDEAD_BEEF};
      vecs[10] = '{1'b0, 2'd2, 1'b0, 32'h40,       32'h0,        32'hDEAD_BEEF, 32'h0};
      vecs[11] = '{1'b0, 2'd0, 1'b1, 32'h33,       32'h0,        32'hFFFF_FFCA, 32'h0};
      vecs[12] = '{1'b0, 2'd3, 1'b1, 32'h20,       32'h0,        32'h0000_0080, 32'h0};
      vecs[13] = '{1'b0, 2'd2, 1'b0, 32'hFFFF_FFFE, 32'h0,        32'h4433_2211, 32'h0};
      vecs[14] = '{1'b0, 2'd1, 1'b1, 32'h41,       32'h0,        32'hFFFF_ADBE, 32'h0};

      repeat (3) @(negedge clk);
      chk("rst_cmdReady", 33'(cmdReady), 33'(0));
      chk("rst_readReq", 33'(readReq), 33'(0));
      chk("rst_writeReq", 33'(writeReq), 33'(0));
      chk("rst_rspValid", 33'(rspValid), 33'(0));
      chk("rst_rspErr", 33'(rspErr), 33'(0));
      chk("rst_rspData", {1'b0, rspData}, 33'(0));
      chk("rst_ramAddress", {1'b0, ramAddress}, 33'(0));
      chk("rst_ramOut", {1'b0, ramOut}, 33'(0));
      chk("rst_state", 33'(fsm_state), 33'(0));
      reset = 1'b0;
      @(negedge clk);
      chk("rst_release_cmdReady", 33'(cmdReady), 33'(1));

      for (int i = 0; i < 15; i++)
         do_cmd(vecs[i].wr, vecs[i].sz, vecs[i].sgn, vecs[i].addr, vecs[i].data,
                {1'b0, vecs[i].exp_rsp}, vecs[i].exp_wdata);

      // Reset while waiting for a read ack, then a stray double ack while idle.
      ack_en = 1'b0;
      rd0  = rd_pulses;
      wr0  = wr_pulses;
      rsp0 = rsp_pulses;
      cmdValid = 1'b1;
      cmdWrite = 1'b0;
      cmdSize  = 2'd2;
      cmdAddr  = 32'h10;
      @(negedge clk);
      cmdValid = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("midrst_cmdReady_low", 33'(cmdReady), 33'(0));
      chk("midrst_readReq_low", 33'(readReq), 33'(0));
      reset = 1'b0;
      stray_cnt++;
      @(negedge clk);
      chk("midrst_cmdReady_high", 33'(cmdReady), 33'(1));
      repeat (6) @(negedge clk);
      chk("midrst_state_idle", 33'(fsm_state), 33'(0));
      chk("midrst_no_rsp", 33'(rsp_pulses - rsp0), 33'(0));
      chk("midrst_rd_pulses", 33'(rd_pulses - rd0), 33'(1));
      chk("midrst_wr_pulses", 33'(wr_pulses - wr0), 33'(0));
      ack_en = 1'b1;

`ifdef MEMREQ_TIMEOUT_EN
      ack_en = 1'b0;
      cmdValid = 1'b1;
      cmdWrite = 1'b0;
      cmdSize  = 2'd2;
      cmdAddr  = 32'h10;
      @(negedge clk);
      cmdValid = 1'b0;
      n = 0;
      while (rspValid !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("tmo_latency", 33'(n), 33'(5));
      chk("tmo_rsp", {rspErr, rspData}, {1'b1, 32'h0});
      @(negedge clk);
      do_cmd(1'b1, 2'd0, 1'b0, 32'h30, 32'h55, {1'b1, 32'h0}, 32'h0);
      do_cmd(1'b1, 2'd2, 1'b0, 32'h40, 32'h77, {1'b1, 32'h0}, 32'h77);
      ack_en = 1'b1;
`else
      n = 0;
`endif

      for (int i = 0; i < 24; i++) begin
         logic        wr;
         logic [1:0]  sz;
         logic        sgn;
         logic [31:0] a;
         logic [31:0] d;
         logic [31:0] w;
         wr  = 1'($urandom_range(0, 1));
         sz  = 2'($urandom_range(0, 3));
         sgn = 1'($urandom_range(0, 1));
         a   = 32'h100 + 32'($urandom_range(0, 28));
         d   = $urandom;
         w   = rd_mem(a);
         if (wr)
            do_cmd(wr, sz, sgn, a, d, {1'b0, 32'h0}, model_merge(w, d, sz));
         else
            do_cmd(wr, sz, sgn, a, d, {1'b0, model_load(w, sz, sgn)}, 32'h0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
